data_sram_responder: RTL and testbench

//  Data-side SRAM responder answering the data_sram_* request bus driven by the EX stage.

---
 rtl/data_sram_responder_if.sv | 24 ++
 rtl/data_sram_responder.sv | 136 +++++++++++++
 tb/tb_data_sram_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// Request/response bus between the EX-stage initiator and the data SRAM responder.
interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en,
      output data_sram_wen,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_wen,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data SRAM with byte-lane writes and registered reads.
// Optional read wait states are compiled in with the DATA_SRAM_WAIT_EN macro.
module data_sram_responder #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   data_sram_responder_if.slave  bus,
   output logic                  stallreq_mem
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] idx_s;
   logic              accept_s;
   logic              wr_s;
   logic              rd_s;
   logic [31:0]       rdata_q;
   logic [31:0]       rdata_d;
   logic              unused_addr_s;

   // Byte offset and bits above the RAM depth are dropped, so addresses alias.
   assign idx_s         = bus.data_sram_addr[ADDR_W+1:2];
   assign unused_addr_s = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};
   assign wr_s          = accept_s && bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
   assign rd_s          = accept_s && bus.data_sram_en && (bus.data_sram_wen == 4'b0000);

   // Byte-lane write port; contents survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_s && bus.data_sram_wen[i]) begin
            mem_q[idx_s][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

`ifdef DATA_SRAM_WAIT_EN
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;
   localparam logic [3:0] EFF_W   = 4'(WAIT_CYCLES);

   logic [0:0]        state_q;
   logic [0:0]        state_d;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;
   logic [ADDR_W-1:0] lidx_q;
   logic [ADDR_W-1:0] lidx_d;
   logic              stall_q;

   // Requests arriving during the wait phase are ignored.
   assign accept_s = (state_q == ST_IDLE);

   // Next-state logic for the read wait sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lidx_d  = lidx_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_s) begin
               if (EFF_W == 4'd0) begin
                  rdata_d = mem_q[idx_s];
               end else begin
                  lidx_d  = idx_s;
                  cnt_d   = EFF_W;
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               rdata_d = mem_q[lidx_q];
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Sequencer state and the registered stall flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         lidx_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lidx_q  <= lidx_d;
         stall_q <= (state_d == ST_WAIT);
      end
   end

   assign stallreq_mem = stall_q;
`else
   logic [3:0] unused_wait_s;

   assign unused_wait_s = 4'(WAIT_CYCLES);
   assign accept_s      = 1'b1;
   assign stallreq_mem  = 1'b0;

   // Single-cycle read path.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_s) begin
         rdata_d = mem_q[idx_s];
      end else begin
         rdata_d = rdata_q;
      end
   end
`endif

   // Read data register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q <= 32'h0000_0000;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign bus.data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed, table-driven bench for data_sram_responder (both wait-state builds).
module tb_data_sram_responder;

`ifdef DATA_SRAM_WAIT_EN
   localparam int TB_W   = 2;
   localparam int DUT_WC = 2;
`else
   localparam int TB_W   = 0;
   localparam int DUT_WC = 5;
`endif

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   logic stallreq_mem;
   int   checks = 0;
   int   errors = 0;

   data_sram_responder_if bus ();

   data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(DUT_WC)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bus          (bus),
      .stallreq_mem (stallreq_mem)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Caller is at a negedge; request is accepted at the next posedge.
   task automatic do_req(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
      bus.data_sram_en    = 1'b1;
      bus.data_sram_addr  = addr;
      bus.data_sram_wen   = wen;
      bus.data_sram_wdata = wdata;
      @(negedge clk);
      bus.data_sram_en    = 1'b0;
      bus.data_sram_wen   = 4'h0;
   endtask

   task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      do_req(addr, 4'h0, 32'h0);
      for (int i = 0; i < TB_W; i++) begin
         chk({name, "_stall"}, {31'b0, stallreq_mem}, 32'h1);
         @(negedge clk);
      end
      chk(name, bus.data_sram_rdata, exp);
      chk({name, "_nostall"}, {31'b0, stallreq_mem}, 32'h0);
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0040, 4'hF,    32'h1122_3344, 32'h0000_0000};
      vecs[1]  = '{32'h0000_0040, 4'b0101, 32'hAABB_CCDD, 32'h0000_0000};
      vecs[2]  = '{32'h0000_0040, 4'h0,    32'h0,         32'h11BB_33DD};
      vecs[3]  = '{32'h0000_1000, 4'hF,    32'hDEAD_BEEF, 32'h11BB_33DD};
      vecs[4]  = '{32'h0000_0000, 4'h0,    32'h0,         32'hDEAD_BEEF};
      vecs[5]  = '{32'h0000_1002, 4'h0,    32'h0,         32'hDEAD_BEEF};
      vecs[6]  = '{32'h0000_0003, 4'b0010, 32'h0000_AB00, 32'hDEAD_BEEF};
      vecs[7]  = '{32'h0000_4000, 4'h0,    32'h0,         32'hDEAD_ABEF};
      vecs[8]  = '{32'h0000_0004, 4'hF,    32'h0102_0304, 32'hDEAD_ABEF};
      vecs[9]  = '{32'h0000_0008, 4'hF,    32'h0506_0708, 32'hDEAD_ABEF};
      vecs[10] = '{32'h0000_0FFC, 4'hF,    32'hCAFE_F00D, 32'hDEAD_ABEF};
      vecs[11] = '{32'h0000_0FFE, 4'b1100, 32'h1234_0000, 32'hDEAD_ABEF};
      vecs[12] = '{32'h0000_1FFC, 4'h0,    32'h0,         32'h1234_F00D};
      vecs[13] = '{32'h0000_0004, 4'h0,    32'h0,         32'h0102_0304};

      bus.data_sram_en    = 1'b0;
      bus.data_sram_wen   = 4'h0;
      bus.data_sram_addr  = 32'h0;
      bus.data_sram_wdata = 32'h0;
      #2 resetn = 1'b0;
      #1;
      chk("reset_rdata", bus.data_sram_rdata, 32'h0);
      chk("reset_stall", {31'b0, stallreq_mem}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 14; v++) begin
         if (vecs[v].wen == 4'h0) begin
            read_chk($sformatf("vec%0d_read", v), vecs[v].addr, vecs[v].exp);
         end else begin
            do_req(vecs[v].addr, vecs[v].wen, vecs[v].wdata);
            chk($sformatf("vec%0d_write_hold", v), bus.data_sram_rdata, vecs[v].exp);
         end
      end

      // Idle cycles with en=0 must not disturb rdata.
      bus.data_sram_addr = 32'h0000_0008;
      repeat (3) @(negedge clk);
      chk("idle_hold", bus.data_sram_rdata, 32'h0102_0304);

      // Asynchronous reset mid-run, checked before any clock edge.
      #2 resetn = 1'b0;
      #1;
      chk("async_reset_rdata", bus.data_sram_rdata, 32'h0);
      chk("async_reset_stall", {31'b0, stallreq_mem}, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      read_chk("ram_kept", 32'h0000_0040, 32'h11BB_33DD);

`ifdef DATA_SRAM_WAIT_EN
      // Requests during WAIT are ignored, including a write.
      bus.data_sram_en    = 1'b1;
      bus.data_sram_addr  = 32'h0000_0008;
      bus.data_sram_wen   = 4'h0;
      @(negedge clk);
      chk("wait_c1_stall", {31'b0, stallreq_mem}, 32'h1);
      chk("wait_c1_rdata", bus.data_sram_rdata, 32'h11BB_33DD);
      bus.data_sram_addr  = 32'h0000_0004;
      bus.data_sram_wen   = 4'hF;
      bus.data_sram_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("wait_c2_stall", {31'b0, stallreq_mem}, 32'h1);
      chk("wait_c2_rdata", bus.data_sram_rdata, 32'h11BB_33DD);
      bus.data_sram_addr  = 32'h0000_0040;
      bus.data_sram_wen   = 4'h0;
      @(negedge clk);
      bus.data_sram_en    = 1'b0;
      chk("wait_done_rdata", bus.data_sram_rdata, 32'h0506_0708);
      chk("wait_done_stall", {31'b0, stallreq_mem}, 32'h0);
      @(negedge clk);
      chk("wait_no_extra", bus.data_sram_rdata, 32'h0506_0708);
      read_chk("wait_write_ignored", 32'h0000_0004, 32'h0102_0304);

      // Reset during WAIT drops the pending read.
      do_req(32'h0000_0008, 4'h0, 32'h0);
      chk("rstwait_stall_pre", {31'b0, stallreq_mem}, 32'h1);
      #2 resetn = 1'b0;
      #1;
      chk("rstwait_stall", {31'b0, stallreq_mem}, 32'h0);
      chk("rstwait_rdata", bus.data_sram_rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("rstwait_dropped", bus.data_sram_rdata, 32'h0);
      resetn = 1'b1;
      @(negedge clk);
      read_chk("rstwait_next", 32'h0000_0008, 32'h0506_0708);
`else
      // Streaming reads: one word per cycle, no stall.
      bus.data_sram_en   = 1'b1;
      bus.data_sram_wen  = 4'h0;
      bus.data_sram_addr = 32'h0000_0000;
      @(negedge clk);
      chk("stream0", bus.data_sram_rdata, 32'hDEAD_ABEF);
      chk("stream0_stall", {31'b0, stallreq_mem}, 32'h0);
      bus.data_sram_addr = 32'h0000_0004;
      @(negedge clk);
      chk("stream1", bus.data_sram_rdata, 32'h0102_0304);
      chk("stream1_stall", {31'b0, stallreq_mem}, 32'h0);
      bus.data_sram_addr = 32'h0000_0008;
      @(negedge clk);
      bus.data_sram_en   = 1'b0;
      chk("stream2", bus.data_sram_rdata, 32'h0506_0708);
      chk("stream2_stall", {31'b0, stallreq_mem}, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
